// File: rtl/demux4_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Channel indices; also the bit positions in out_valid / out_ready.
    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

endpackage

// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one input stream, four output channels, counter taps.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready / out_ready carried per stream; slave = demux side, master = surroundings.
interface demux4_stream_if
    import demux4_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);

    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_data_a;
    logic [DATA_W-1:0] out_data_b;
    logic [DATA_W-1:0] out_data_c;
    logic [DATA_W-1:0] out_data_d;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;

    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_c;
    logic [CNT_W-1:0]  cnt_d;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data_a, out_data_b, out_data_c, out_data_d,
        input  out_valid, cnt_a, cnt_b, cnt_c, cnt_d
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data_a, out_data_b, out_data_c, out_data_d,
        output out_valid, cnt_a, cnt_b, cnt_c, cnt_d
    );

endinterface

// File: rtl/demux4_stream_slot.sv
// One-entry output holding register with a wrapping delivered-word counter.
// Latency: 1 cycle from load to valid.
// Backpressure: space = !valid || out_ready, so a load may coincide with delivery.
// Ports: clk, rst (sync, active-high); load/load_data in; out_ready in;
//        space, data, valid, cnt out.
module demux_slot #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              space,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [CNT_W-1:0]  cnt
);

    logic deliver;

    assign deliver = valid && out_ready;
    assign space   = !valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            // A load wins over the valid-clear so drain+load in one cycle keeps valid high.
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (deliver) begin
                valid <= 1'b0;
            end
            // Data is intentionally kept after delivery; only valid drops.
            if (deliver) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demux: routes each accepted word to channel in_sel.
// Latency: 1 cycle from input accept to out_valid on the selected channel.
// Backpressure: in_ready reflects only the selected channel; a stalled channel never blocks others.
// Ports: clk, rst (sync, active-high); bus (demux4_stream_if.slave) carries in_*/out_*/cnt_*.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    demux4_stream_if.slave bus
);

    logic [NUM_CH-1:0] space;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] valid;
    logic [DATA_W-1:0] data [NUM_CH];
    logic [CNT_W-1:0]  cnt  [NUM_CH];
    logic              in_ready;

    assign in_ready = !rst && space[bus.in_sel];

    // One-hot load enable; at most one channel loads per cycle.
    always_comb begin
        load = '0;
        if (bus.in_valid && in_ready && !rst) begin
            load[bus.in_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[i]),
            .space     (space[i]),
            .data      (data[i]),
            .valid     (valid[i]),
            .cnt       (cnt[i])
        );
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid;
    assign bus.out_data_a = data[CH_A];
    assign bus.out_data_b = data[CH_B];
    assign bus.out_data_c = data[CH_C];
    assign bus.out_data_d = data[CH_D];
    assign bus.cnt_a      = cnt[CH_A];
    assign bus.cnt_b      = cnt[CH_B];
    assign bus.cnt_c      = cnt[CH_C];
    assign bus.cnt_d      = cnt[CH_D];

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed scenarios plus randomized traffic against a channel model.
// Latency: model expects outputs one cycle after accept.
// Backpressure: upstream holds in_sel/in_data while stalled.
module tb_demux4_stream;

    logic clk;
    logic rst;

    demux4_stream_if #(.DATA_W(4), .CNT_W(8)) bus ();

    demux4_stream #(.DATA_W(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Behavioural model: four independent one-word mailboxes with delivery tallies.
    bit       m_full [4];
    bit [3:0] m_word [4];
    int       m_tally[4];
    bit       stalled;
    bit       chk_en;
    int       errors;
    int       checks;

    function automatic bit model_ready();
        int s;
        s = int'(bus.in_sel);
        return !rst && (!m_full[s] || bus.out_ready[s]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_all();
        chk("m_in_ready", bus.in_ready, model_ready());
        chk("m_out_valid", bus.out_valid, {m_full[3], m_full[2], m_full[1], m_full[0]});
        chk("m_data_a", bus.out_data_a, m_word[0]);
        chk("m_data_b", bus.out_data_b, m_word[1]);
        chk("m_data_c", bus.out_data_c, m_word[2]);
        chk("m_data_d", bus.out_data_d, m_word[3]);
        chk("m_cnt_a", bus.cnt_a, m_tally[0] % 256);
        chk("m_cnt_b", bus.cnt_b, m_tally[1] % 256);
        chk("m_cnt_c", bus.cnt_c, m_tally[2] % 256);
        chk("m_cnt_d", bus.cnt_d, m_tally[3] % 256);
    endtask

    task automatic model_update();
        bit take;
        int s;
        take    = bus.in_valid && model_ready();
        stalled = !rst && bus.in_valid && !model_ready();
        s       = int'(bus.in_sel);
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                m_full[c]  = 0;
                m_word[c]  = 0;
                m_tally[c] = 0;
            end else begin
                if (m_full[c] && bus.out_ready[c]) begin
                    m_tally[c] = m_tally[c] + 1;
                    m_full[c]  = 0;
                end
                if (take && s == c) begin
                    m_full[c] = 1;
                    m_word[c] = bus.in_data;
                end
            end
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [3:0] dat);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = dat;
    endtask

    // Upstream protocol: select/data must not change while a word is stalled.
    logic       prev_stall = 1'b0;
    logic [1:0] prev_sel   = 2'd0;
    logic [3:0] prev_data  = 4'd0;
    always @(negedge clk) begin
        if (!rst && prev_stall && bus.in_valid) begin
            assert (bus.in_sel == prev_sel && bus.in_data == prev_data)
                else $error("protocol: select or data changed under stall");
        end
        prev_stall <= !rst && bus.in_valid && !bus.in_ready;
        prev_sel   <= bus.in_sel;
        prev_data  <= bus.in_data;
    end

    initial begin
        errors        = 0;
        checks        = 0;
        chk_en        = 0;
        stalled       = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 4'd0;
        bus.out_ready = 4'b0000;

        // Reset state
        step();
        step();
        chk_en = 1;
        chk("rst_out_valid", bus.out_valid, 4'b0000);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_cnt_a", bus.cnt_a, 8'd0);
        rst = 1'b0;
        step();

        // Single routing to channel c
        send(2'd2, 4'hA);
        bus.out_ready = 4'b0100;
        step();
        bus.in_valid = 1'b0;
        chk("route_valid", bus.out_valid, 4'b0100);
        chk("route_data_c", bus.out_data_c, 4'hA);
        step();
        chk("route_drained", bus.out_valid, 4'b0000);
        chk("route_cnt_c", bus.cnt_c, 8'd1);
        chk("route_cnt_a", bus.cnt_a, 8'd0);

        // Streaming 0..7 into channel a
        bus.out_ready = 4'b0001;
        for (int w = 0; w < 8; w++) begin
            send(2'd0, w[3:0]);
            #1;
            chk("stream_in_ready", bus.in_ready, 1'b1);
            step();
            chk("stream_data_a", bus.out_data_a, w);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_cnt_a", bus.cnt_a, 8'd8);

        // Per-channel backpressure
        bus.out_ready = 4'b0000;
        send(2'd3, 4'h5);
        step();
        send(2'd3, 4'h6);
        #1;
        chk("bp_in_ready_d", bus.in_ready, 1'b0);
        step();
        chk("bp_data_d_held", bus.out_data_d, 4'h5);
        bus.in_valid = 1'b0;
        step();
        send(2'd1, 4'h7);
        #1;
        chk("bp_in_ready_b", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_data_b", bus.out_data_b, 4'h7);

        // Simultaneous drain + load on channel d
        bus.out_ready = 4'b1000;
        step();
        bus.out_ready = 4'b0000;
        send(2'd3, 4'h1);
        step();
        chk("dl_cnt_d_before", bus.cnt_d, 8'd1);
        send(2'd3, 4'h2);
        bus.out_ready = 4'b1000;
        step();
        bus.in_valid = 1'b0;
        chk("dl_valid_d", bus.out_valid[3], 1'b1);
        chk("dl_data_d", bus.out_data_d, 4'h2);
        chk("dl_cnt_d", bus.cnt_d, 8'd2);
        bus.out_ready = 4'b1111;
        step();

        // Counter wrap on channel a from a clean reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 4'b0001;
        for (int w = 0; w < 256; w++) begin
            send(2'd0, 4'($urandom_range(0, 15)));
            step();
        end
        bus.in_valid = 1'b0;
        chk("wrap_cnt_a_255", bus.cnt_a, 8'd255);
        step();
        chk("wrap_cnt_a_0", bus.cnt_a, 8'd0);
        chk("wrap_cnt_b", bus.cnt_b, 8'd0);
        chk("wrap_cnt_d", bus.cnt_d, 8'd0);

        // Reset mid-operation
        for (int w = 0; w < 3; w++) begin
            send(2'd0, 4'(w));
            step();
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'b0000;
        send(2'd0, 4'h9);
        step();
        send(2'd2, 4'hC);
        step();
        chk("mid_cnt_a", bus.cnt_a, 8'd3);
        chk("mid_valid", bus.out_valid, 4'b0101);
        rst = 1'b1;
        send(2'd1, 4'hE);
        #1;
        chk("mid_in_ready_rst", bus.in_ready, 1'b0);
        step();
        chk("mid_valid_cleared", bus.out_valid, 4'b0000);
        chk("mid_cnt_a_cleared", bus.cnt_a, 8'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("mid_word_dropped", bus.out_valid, 4'b0000);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if (!stalled) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = 4'($urandom_range(0, 15));
            end
            bus.out_ready = 4'($urandom_range(0, 15));
            step();
        end
        bus.in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- Registered 1-to-4 stream demultiplexer: the distributing counterpart of the team's 4:1 mux.
- Routes one input word per handshake to output channel a, b, c or d, selected by a 2-bit select.
- Each channel has a one-entry holding register and its own valid/ready handshake.
- Each channel has a wrapping delivered-word counter, used as a debug and observability tap.

Parameters:
- DATA_W, 4, width of each data word.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  DATA_W  input word.
- in_sel  input  2  destination channel: 0=a, 1=b, 2=c, 3=d.
- in_valid  input  1  input word and select are valid.
- in_ready  output  1  block accepts the input this cycle.
- out_data_a, out_data_b, out_data_c, out_data_d  output  DATA_W each  per-channel held word.
- out_valid  output  4  bit i = channel i holds a word (bit0=a ... bit3=d).
- out_ready  input  4  bit i = channel i consumer accepts.
- cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  words delivered on each channel.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, all out_data_*=0, all cnt_*=0. in_ready=0 while rst=1.
- in_ready (combinational, rst=0): in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - Depends only on the selected channel.
  - A full, stalled channel does not block words bound for other channels.
- Accept: in_valid && in_ready at edge.
  - Next cycle: out_data_<in_sel> = in_data and out_valid[in_sel]=1.
  - Latency is exactly 1 cycle from accept to out_valid.
  - No combinational path from in_data to out_data.
- Output handshake: out_valid[i] && out_ready[i] at edge means channel i delivers its word.
  - Without a load on channel i that cycle, out_valid[i] clears next cycle.
  - out_data_<i> retains its last value after delivery; it is not cleared.
- Simultaneous delivery and load on the same channel:
  - out_valid[i] stays 1 and out_data_<i> takes the new word.
  - Full throughput: 1 word/cycle to a channel whose consumer holds out_ready=1.
- Stall: channel full and out_ready=0 means in_ready=0 and the input is not taken.
  - Upstream must hold in_data/in_sel stable while in_valid && !in_ready.
  - A select change under stall is a protocol violation. The bench flags it via assertion; behaviour is undefined.
- out_valid[i] is never dropped without delivery. out_data_<i> is stable while out_valid[i] && !out_ready[i].
- Only one channel loads per cycle. Any subset of channels may deliver in the same cycle.
- Counters: cnt_<i> increments by 1 on each output handshake of channel i.
  - Wraps from 2^CNT_W-1 to 0 with no saturation or flag.
  - Counters are independent; simultaneous deliveries increment each counter.
- out_ready on a channel with out_valid=0 has no effect: no count, no state change.
- Reset mid-operation:
  - All held words are discarded and counters cleared on the reset edge.
  - A word presented during the reset cycle is not accepted.
  - Normal operation resumes the first cycle after rst deasserts.

Decomposition:
- Shared package demux4_pkg holds:
  - localparam NUM_CH=4 and SEL_W=2.
  - Channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3.
- Sub-module demux_slot, instantiated 4 times. Each instance:
  - One-entry register, i.e. data plus valid.
  - Inputs: load, load_data, out_ready.
  - Outputs: space (= !valid || out_ready), data, valid, CNT_W delivered counter.
- Top level:
  - Decodes in_sel into a one-hot load enable gated by in_valid && in_ready && !rst.
  - Muxes the slot space signals onto in_ready.

Test Plan:
- Reset, then single routing: in_data=4'hA, in_sel=2, in_valid for 1 cycle, out_ready=4'b0100 -> next cycle out_valid=4'b0100, out_data_c=4'hA; following cycle out_valid=0, cnt_c=1, others 0.
- Streaming: 8 words 0..7 to sel=0, out_ready=4'b0001 throughout -> in_ready held 1, out_data_a shows 0..7 on consecutive cycles, cnt_a=8.
- Per-channel backpressure: fill d with 4'h5 and out_ready[3]=0. Then send 4'h6 to d -> in_ready=0, out_data_d stays 4'h5. Then send 4'h7 to b -> in_ready=1, out_data_b=4'h7 next cycle.
- Simultaneous drain+load: d holds 4'h1, out_ready[3]=1, new word 4'h2 to d the same cycle -> out_valid[3] stays 1, out_data_d=4'h2, cnt_d increments by 1.
- Counter wrap (CNT_W=8): 256 deliveries on channel a -> cnt_a returns to 0, other counters unchanged.
- Reset mid-operation: channels a and c full, cnt_a=3; assert rst 1 cycle with in_valid=1 -> out_valid=0, all cnt=0, in_ready=0 during rst, presented word not delivered.
